fft_iter_ctrl: RTL and testbench

//  Sequencer for the iterative radix-2 DIT in-place FFT core. After START, walks
//  LOG2N stages of N/2 butterflies. Per butterfly it issues the read pair

---
 rtl/fft_iter_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fft_iter_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fft_iter_ctrl.sv
// Sequencer for an iterative radix-2 DIT in-place FFT: read/twiddle issue plus delayed write-back.
// Optional FFT_CTRL_HOLD_EN adds a HOLD input that stalls issue while in RUN.
module fft_iter_ctrl #(
  parameter int unsigned LOG2N  = 4,
  parameter int unsigned BF_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
`ifdef FFT_CTRL_HOLD_EN
  input  logic             HOLD,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             RD_EN,
  output logic [LOG2N-1:0] RD_A,
  output logic [LOG2N-1:0] RD_B,
  output logic [LOG2N-2:0] TW_ADDR,
  output logic             W_EN,
  output logic             W_LAY_EN,
  output logic             WR_EN,
  output logic [LOG2N-1:0] WR_A,
  output logic [LOG2N-1:0] WR_B
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [KW-1:0] KLast = '1;
  localparam logic [SW-1:0] SLast = SW'(LOG2N - 1);
  localparam logic [CW-1:0] CLast = CW'(BF_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            issue, lay_en;
  logic            hold_w;

  logic [LOG2N-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [KW-1:0]    tw_q, tw_d;

  logic [BF_LAT-1:0] dl_en_q, dl_en_d;
  logic [LOG2N-1:0]  dl_a_q [BF_LAT];
  logic [LOG2N-1:0]  dl_a_d [BF_LAT];
  logic [LOG2N-1:0]  dl_b_q [BF_LAT];
  logic [LOG2N-1:0]  dl_b_d [BF_LAT];

`ifdef FFT_CTRL_HOLD_EN
  assign hold_w = HOLD;
`else
  assign hold_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    lay_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StRun;
          s_d     = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        if (!hold_w) begin
          issue = 1'b1;
          if (k_q == KLast) begin
            state_d = StDrain;
            cnt_d   = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StDrain: begin
        // Waiting out BF_LAT keeps the next stage's reads behind this stage's writes.
        if (cnt_q == CLast) begin
          if (s_q == SLast) begin
            state_d = StFin;
          end else begin
            state_d = StRun;
            s_d     = s_q + SW'(1);
            k_d     = '0;
            lay_en  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Addresses for the butterfly that will be presented next cycle.
  always_comb begin
    logic [LOG2N-1:0] k_ext, mask, lo;
    k_ext  = LOG2N'(k_d);
    mask   = (LOG2N'(1) << s_d) - LOG2N'(1);
    lo     = k_ext & mask;
    rd_a_d = ((k_ext & ~mask) << 1) | lo;
    rd_b_d = rd_a_d | (LOG2N'(1) << s_d);
    tw_d   = KW'(lo << (SLast - s_d));
    if (state_d != StRun) begin
      rd_a_d = '0;
      rd_b_d = '0;
      tw_d   = '0;
    end
  end

  always_comb begin
    dl_en_d[0] = issue;
    dl_a_d[0]  = rd_a_q;
    dl_b_d[0]  = rd_b_q;
    for (int i = 1; i < BF_LAT; i++) begin
      dl_en_d[i] = dl_en_q[i-1];
      dl_a_d[i]  = dl_a_q[i-1];
      dl_b_d[i]  = dl_b_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      dl_en_q <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a_q[i] <= '0;
        dl_b_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      dl_en_q <= dl_en_d;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a_q[i] <= dl_a_d[i];
        dl_b_q[i] <= dl_b_d[i];
      end
    end
  end

  assign BUSY     = (state_q == StRun) || (state_q == StDrain);
  assign DONE     = (state_q == StFin);
  assign RD_EN    = issue;
  assign W_EN     = issue;
  assign W_LAY_EN = lay_en;
  assign RD_A     = rd_a_q;
  assign RD_B     = rd_b_q;
  assign TW_ADDR  = tw_q;
  assign WR_EN    = dl_en_q[BF_LAT-1];
  assign WR_A     = dl_a_q[BF_LAT-1];
  assign WR_B     = dl_b_q[BF_LAT-1];

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Scoreboard bench for fft_iter_ctrl at LOG2N=3, BF_LAT=2; HOLD scenario under FFT_CTRL_HOLD_EN.
module tb_fft_iter_ctrl;
  localparam int L   = 3;
  localparam int LAT = 2;
  localparam int HALF = 4;
  localparam int STG  = HALF + LAT;

  logic       CLK = 1'b0;
  logic       RST, START;
`ifdef FFT_CTRL_HOLD_EN
  logic       HOLD;
`endif
  logic       BUSY, DONE, RD_EN, W_EN, W_LAY_EN, WR_EN;
  logic [2:0] RD_A, RD_B, WR_A, WR_B;
  logic [1:0] TW_ADDR;

  always #5 CLK = ~CLK;

  fft_iter_ctrl #(.LOG2N(L), .BF_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START),
`ifdef FFT_CTRL_HOLD_EN
    .HOLD(HOLD),
`endif
    .BUSY(BUSY), .DONE(DONE), .RD_EN(RD_EN), .RD_A(RD_A), .RD_B(RD_B),
    .TW_ADDR(TW_ADDR), .W_EN(W_EN), .W_LAY_EN(W_LAY_EN), .WR_EN(WR_EN),
    .WR_A(WR_A), .WR_B(WR_B)
  );

  typedef struct {int cyc; logic [2:0] a; logic [2:0] b; logic [1:0] tw;} op_t;
  typedef struct {int start; int h;} run_t;

  op_t  rdq[$];
  op_t  wrq[$];
  run_t runs[$];
  int   cyc, errors, checks, wr_cnt, base;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected transform: h stall cycles inserted after the very first issue.
  task automatic plan(input int start, input int h);
    op_t  e;
    run_t r;
    int   span;
    r.start = start;
    r.h     = h;
    runs.push_back(r);
    for (int s = 0; s < L; s++) begin
      span = 1 << s;
      for (int k = 0; k < HALF; k++) begin
        e.cyc = start + 1 + s * STG + k + ((s == 0 && k == 0) ? 0 : h);
        e.a   = 3'((k % span) + (k / span) * 2 * span);
        e.b   = 3'(int'(e.a) + span);
        e.tw  = 2'((k % span) * (HALF / span));
        rdq.push_back(e);
        e.cyc = e.cyc + LAT;
        wrq.push_back(e);
      end
    end
  endtask

  task automatic clear_model();
    rdq.delete();
    wrq.delete();
    runs.delete();
  endtask

  task automatic check_cycle();
    logic er, ew, eb, ed, el;
    op_t  e;
    int   st;
    #2;
    er = (rdq.size() > 0) && (rdq[0].cyc == cyc);
    ew = (wrq.size() > 0) && (wrq[0].cyc == cyc);
    chk("rd_en", 16'(RD_EN), 16'(er));
    chk("w_en", 16'(W_EN), 16'(er));
    if (er) begin
      e = rdq.pop_front();
      chk("rd_a", 16'(RD_A), 16'(e.a));
      chk("rd_b", 16'(RD_B), 16'(e.b));
      chk("tw_addr", 16'(TW_ADDR), 16'(e.tw));
    end
    chk("wr_en", 16'(WR_EN), 16'(ew));
    if (WR_EN) wr_cnt++;
    if (ew) begin
      e = wrq.pop_front();
      chk("wr_a", 16'(WR_A), 16'(e.a));
      chk("wr_b", 16'(WR_B), 16'(e.b));
    end
    eb = 1'b0; ed = 1'b0; el = 1'b0;
    foreach (runs[i]) begin
      st = runs[i].start + runs[i].h;
      if (cyc >= runs[i].start + 1 && cyc <= st + L * STG) eb = 1'b1;
      if (cyc == st + L * STG + 1) ed = 1'b1;
      if (cyc == st + STG || cyc == st + 2 * STG) el = 1'b1;
    end
    chk("busy", 16'(BUSY), 16'(eb));
    chk("done", 16'(DONE), 16'(ed));
    chk("w_lay_en", 16'(W_LAY_EN), 16'(el));
  endtask

  task automatic step();
    check_cycle();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    errors = 0; checks = 0; wr_cnt = 0; cyc = 0;
    RST = 1'b1; START = 1'b0;
`ifdef FFT_CTRL_HOLD_EN
    HOLD = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    step();
    chk("reset_rd_a", 16'(RD_A), 16'h0);
    chk("reset_rd_b", 16'(RD_B), 16'h0);
    chk("reset_tw", 16'(TW_ADDR), 16'h0);
    chk("reset_wr_a", 16'(WR_A), 16'h0);
    chk("reset_wr_b", 16'(WR_B), 16'h0);
    RST = 1'b0;
    step();
    step();

    // Full run, START held through the busy/FIN window, then a back-to-back restart.
    base = cyc;
    wr_cnt = 0;
    for (int c = 0; c <= 45; c++) begin
      START = (c == 0) || (c >= 5 && c <= 20);
      if (c == 0) plan(base, 0);
      if (c == 20) plan(base + 20, 0);
      step();
      if (c == 19) chk("wr_count", 16'(wr_cnt), 16'd12);
    end
    START = 1'b0;
    clear_model();

    // Reset in stage 1, then a fresh start.
    base = cyc;
    for (int c = 0; c <= 55; c++) begin
      START = (c == 0) || (c == 30);
      RST   = (c == 9);
      if (c == 0) plan(base, 0);
      if (c == 30) plan(base + 30, 0);
      step();
      if (c == 9) clear_model();
    end
    START = 1'b0;
    RST = 1'b0;
    clear_model();

`ifdef FFT_CTRL_HOLD_EN
    // Two-cycle stall after the first issue; HOLD outside RUN is ignored.
    base = cyc;
    for (int c = 0; c <= 25; c++) begin
      START = (c == 0);
      HOLD  = (c == 2) || (c == 3) || (c == 7) || (c == 22);
      if (c == 0) plan(base, 2);
      step();
    end
    START = 1'b0;
    HOLD = 1'b0;
    clear_model();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
